// File: rtl/pacman_game_ctrl.sv
// rtl/pacman_game_ctrl.sv - game-rule sequencer: frame tick, lives, fright mode, ghost enables, score
module pacman_game_ctrl #(
    parameter int FRIGHT_FRAMES  = 600,
    parameter int RESPAWN_FRAMES = 120,
    parameter int START_LIVES    = 2,
    parameter int HIT_DIST       = 64,
    parameter int GHOST_POINTS   = 20,
    parameter int SCORE_W        = 10
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_vs,
    input  logic [19:0]        dist_red,
    input  logic [19:0]        dist_green,
    input  logic [19:0]        dist_aqua,
    input  logic               fruit_eaten,
    input  logic               dot_eaten,
    output logic               reversal,
    output logic               isDefeated,
    output logic               respawn,
    output logic               death,
    output logic [1:0]         lives,
    output logic               red_enable,
    output logic               green_enable,
    output logic               aqua_enable,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        ST_PLAY      = 2'd0,
        ST_FRIGHT    = 2'd1,
        ST_DYING     = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam int SUM_W = SCORE_W + 8;
    localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'((1 << SCORE_W) - 1);

    state_t             r_state;
    logic [9:0]         r_cnt;
    logic [1:0]         r_lives;
    logic [SCORE_W-1:0] r_score;
    logic [2:0]         r_en;
    logic               r_reversal;
    logic               r_defeated;
    logic               r_respawn;
    logic               r_death;

    logic               r_vs_s1;
    logic               r_vs_s2;
    logic               r_vs_s3;
    logic               r_tick;

    logic [2:0]         w_hit;
    logic               w_any_hit;
    logic [1:0]         w_hit_cnt;
    logic [9:0]         w_cnt_inc;
    logic [SUM_W-1:0]   w_dot_add;
    logic [SUM_W-1:0]   w_ghost_add;
    logic [SUM_W-1:0]   w_sum_play;
    logic [SUM_W-1:0]   w_sum_fright;
    logic [SCORE_W-1:0] w_score_play;
    logic [SCORE_W-1:0] w_score_fright;

    // hit vector ordered {red, green, aqua}; a disabled ghost can never hit
    assign w_hit[2]  = (dist_red   < 20'(HIT_DIST)) & r_en[2];
    assign w_hit[1]  = (dist_green < 20'(HIT_DIST)) & r_en[1];
    assign w_hit[0]  = (dist_aqua  < 20'(HIT_DIST)) & r_en[0];
    assign w_any_hit = |w_hit;
    assign w_hit_cnt = {1'b0, w_hit[2]} + {1'b0, w_hit[1]} + {1'b0, w_hit[0]};
    assign w_cnt_inc = r_cnt + 10'd1;

    assign w_dot_add    = {{(SUM_W-1){1'b0}}, dot_eaten};
    assign w_ghost_add  = SUM_W'(w_hit_cnt) * SUM_W'(GHOST_POINTS);
    assign w_sum_play   = SUM_W'(r_score) + w_dot_add;
    assign w_sum_fright = SUM_W'(r_score) + w_dot_add + w_ghost_add;
    assign w_score_play   = (w_sum_play   > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : w_sum_play[SCORE_W-1:0];
    assign w_score_fright = (w_sum_fright > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : w_sum_fright[SCORE_W-1:0];

    // VS is asynchronous: two-flop sync, then a registered rising-edge detect
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vs_s1 <= 1'b0;
            r_vs_s2 <= 1'b0;
            r_vs_s3 <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_vs_s1 <= frame_vs;
            r_vs_s2 <= r_vs_s1;
            r_vs_s3 <= r_vs_s2;
            r_tick  <= r_vs_s2 & ~r_vs_s3;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_PLAY;
            r_cnt      <= 10'd0;
            r_lives    <= 2'(START_LIVES);
            r_score    <= '0;
            r_en       <= 3'b111;
            r_reversal <= 1'b0;
            r_defeated <= 1'b0;
            r_respawn  <= 1'b0;
            r_death    <= 1'b0;
        end else begin
            r_defeated <= 1'b0;
            if (r_tick) begin
                case (r_state)
                    ST_PLAY: begin
                        r_score <= w_score_play;
                        if (w_any_hit) begin
                            r_cnt <= 10'd0;
                            if (r_lives == 2'd0) begin
                                r_state    <= ST_GAME_OVER;
                                r_death    <= 1'b1;
                                r_reversal <= 1'b0;
                                r_respawn  <= 1'b0;
                            end else begin
                                r_state    <= ST_DYING;
                                r_lives    <= r_lives - 2'd1;
                                r_defeated <= 1'b1;
                                r_respawn  <= 1'b1;
                            end
                        end else if (fruit_eaten) begin
                            r_state    <= ST_FRIGHT;
                            r_cnt      <= 10'd0;
                            r_reversal <= 1'b1;
                        end
                    end
                    ST_FRIGHT: begin
                        r_score <= w_score_fright;
                        r_en    <= r_en & ~w_hit;
                        if (fruit_eaten) begin
                            r_cnt <= 10'd0;
                        end else if (w_cnt_inc == 10'(FRIGHT_FRAMES - 1)) begin
                            r_state    <= ST_PLAY;
                            r_cnt      <= 10'd0;
                            r_reversal <= 1'b0;
                            r_en       <= 3'b111;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    ST_DYING: begin
                        if (w_cnt_inc == 10'(RESPAWN_FRAMES - 1)) begin
                            r_state   <= ST_PLAY;
                            r_cnt     <= 10'd0;
                            r_respawn <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_death    <= 1'b1;
                        r_reversal <= 1'b0;
                        r_respawn  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign reversal     = r_reversal;
    assign isDefeated   = r_defeated;
    assign respawn      = r_respawn;
    assign death        = r_death;
    assign lives        = r_lives;
    assign red_enable   = r_en[2];
    assign green_enable = r_en[1];
    assign aqua_enable  = r_en[0];
    assign score        = r_score;
    assign state_dbg    = r_state;

endmodule
